fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
- Instruction fetch stage directly upstream of decode / register-file read in the single-cycle core.
- Owns the word-addressed fetch PC and drives the synchronous instruction memory, which has 1-cycle read latency.
- Buffers returned words with their PCs in a small prefetch FIFO and presents them to the core over a valid/ready handshake.
- Accepts a redirect (branch/JAL/JALR target) that flushes the FIFO and restarts fetch.

Parameters:
- ADDR_W, 10, width of the word address / PC.
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  ADDR_W  instruction memory word address.
- imem_rden  output  1  read request; memory captures imem_addr at the edge ending this cycle.
- imem_q  input  32  instruction word; valid the cycle after a request.
- redirect_valid  input  1  pulse: flush and restart fetch at redirect_pc.
- redirect_pc  input  ADDR_W  redirect target word address.
- out_valid  output  1  FIFO head holds a valid instruction.
- out_ready  input  1  consumer accepts head this cycle.
- out_instr  output  32  head instruction; 32'h00000013 (NOP) when out_valid=0.
- out_pc  output  ADDR_W  PC of head instruction; 0 when out_valid=0.
- fifo_count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, while rst=1):
  - fetch_pc=RESET_PC; FIFO pointers and count=0; inflight=0; kill=0.
  - imem_rden=0, out_valid=0, out_instr=NOP, out_pc=0.
  - Reset mid-operation discards all queued and in-flight words.
- Issue:
  - pop = out_valid & out_ready.
  - imem_rden = !rst & !redirect_valid & (count + inflight - pop < DEPTH).
  - imem_addr = fetch_pc.
  - On issue: fetch_pc <= fetch_pc+1, wrapping modulo 2^ADDR_W (all-ones -> 0); inflight <= 1. Otherwise inflight <= 0.
- Return:
  - If inflight=1 and kill=0 at an edge, push {imem_q, pc_of_request} into FIFO.
  - pc_of_request is a registered copy of imem_addr.
- Pop: on pop, advance read pointer. Simultaneous push+pop leaves count unchanged.
- Credit rule: the credit rule guarantees no push into a full FIFO; a push when full is an assertion failure.
- Throughput: with out_ready held 1, one instruction per cycle in steady state.
- Latency:
  - Request in cycle N -> out_valid in cycle N+2 when the FIFO was empty.
  - Fetch-to-output is therefore 2 cycles; no combinational path from imem_q to outputs.
- Redirect (highest priority):
  - In the redirect_valid cycle, no issue.
  - At the edge: FIFO flushed (count=0), fetch_pc <= redirect_pc, kill <= inflight.
  - The pending word returning next cycle is dropped; kill clears after one cycle.
  - First new request in cycle R+1 at redirect_pc; out_valid no earlier than R+3.
  - A pop in the redirect cycle is treated as accepted, but the flush overrides the pointer update.
- Consumer timing: out_ready may toggle freely; out_instr/out_pc stay stable while out_valid=1 and not popped.
- Consecutive redirects: each one restarts fetch at the latest target; earlier targets are never pushed.
- State per cycle: {empty, filling, full} implied by count. The issue FSM is IDLE (reset) -> FETCH; FETCH stalls when credits are exhausted.

Test Plan:
- Release rst with RESET_PC=0 and out_ready=1 -> out_valid rises 2 cycles after first imem_rden. out_pc sequence is 0,1,2,3… one per cycle; out_instr matches memory contents.
- Hold out_ready=0 for 10 cycles -> fifo_count saturates at 4 and imem_rden drops. Raise out_ready -> 4 buffered words drain in order (PCs 0..3), then fetch resumes at PC 4 with no gap or duplicate.
- Redirect to 0x20 while a read to PC 5 is in flight and the FIFO holds PCs 2..4 -> PCs 2..5 never appear at output. Next delivered out_pc=0x20 three cycles after the redirect; then 0x21.
- Back-to-back redirects to 0x10 then 0x40 on consecutive cycles -> no 0x10 delivered; first out_pc=0x40.
- Start at fetch_pc=0x3FE (via redirect) with ADDR_W=10 -> out_pc sequence 0x3FE, 0x3FF, 0x000, 0x001.
- Assert rst asynchronously mid-stream with the FIFO holding 3 entries -> out_valid=0 and imem_rden=0 immediately. After release, fetch restarts at RESET_PC with no stale word emitted.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - instruction fetch stage with prefetch FIFO
// Drives a 1-cycle-latency instruction memory and buffers returned words with their PCs.
module fetch_prefetch_unit #(
  parameter int                ADDR_W   = 10,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDR_W-1:0]        imem_addr,
  output logic                     imem_rden,
  input  logic [31:0]              imem_q,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int          PW  = $clog2(DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              inflight;
  logic              kill;

  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic              pop;
  logic              push;
  logic              issue;
  logic [CW:0]       credit_need;

  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  assign push       = inflight & ~kill;
  assign fifo_count = count;

  // Occupancy after this cycle's pop, counting the word still in flight as already taken.
  assign credit_need = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign issue       = ~rst & ~redirect_valid & (credit_need < (CW+1)'(DEPTH));

  assign imem_rden = issue;
  assign imem_addr = fetch_pc;

  assign out_instr = out_valid ? instr_mem[rd_ptr] : NOP;
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
        req_pc   <= fetch_pc;
      end
      // Redirect flushes the queue; any pop accepted this cycle is absorbed by the flush.
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        kill     <= inflight;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        kill <= 1'b0;
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !redirect_valid) begin
      instr_mem[wr_ptr] <= imem_q;
      pc_mem[wr_ptr]    <= req_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (redirect_valid || !(push && !pop && count == CW'(DEPTH)));
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - randomized scoreboard bench for fetch_prefetch_unit
module tb_fetch_prefetch_unit;

  localparam int          AW    = 10;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] imem_addr;
  logic          imem_rden;
  logic [31:0]   imem_q = 32'h0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_pc;
  logic [2:0]    fifo_count;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  logic [AW-1:0] exp_q[$];

  fetch_prefetch_unit #(.ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rden(imem_rden), .imem_q(imem_q),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [AW-1:0] a);
    return (32'h9E37_79B1 * {22'd0, a}) ^ {a, 22'h2A5A5};
  endfunction

  // Synchronous instruction memory with one cycle of read latency
  always @(posedge clk) if (imem_rden) imem_q <= instr_of(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Expected delivery after a restart: consecutive PCs from the target, wrapping at 2^AW
  task automatic restart(input logic [AW-1:0] t);
    exp_q.delete();
    for (int i = 0; i < 2000; i++) exp_q.push_back(t + AW'(i));
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [AW-1:0] rpc);
    @(posedge clk);
    if (redirect_valid) restart(redirect_pc);
    #1;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  logic          prev_hold = 1'b0;
  logic [AW-1:0] prev_pc;
  logic [31:0]   prev_instr;
  logic [AW-1:0] e;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      chk("count_max", 32'(fifo_count <= DEPTH), 1);
      chk("valid_vs_count", 32'(out_valid), 32'(fifo_count != 0));
      if (!out_valid) begin
        chk("idle_instr", out_instr, NOP);
        chk("idle_pc", 32'(out_pc), 0);
      end
      if (prev_hold) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_pc", 32'(out_pc), 32'(prev_pc));
        chk("hold_instr", out_instr, prev_instr);
      end
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          chk("exp_empty", 32'(out_pc), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", 32'(out_pc), 32'(e));
          chk("out_instr", out_instr, instr_of(e));
        end
      end
      prev_hold  = out_valid && !out_ready && !redirect_valid;
      prev_pc    = out_pc;
      prev_instr = out_instr;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int  p0;
    bit  got;
    restart('0);
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_rden", 32'(imem_rden), 0);
    chk("rst_instr", out_instr, NOP);
    chk("rst_pc", 32'(out_pc), 0);
    chk("rst_count", 32'(fifo_count), 0);

    // First request right after release; head valid two cycles later
    @(posedge clk); #1;
    out_ready = 1'b1;
    rst = 1'b0;
    #1;
    chk("first_rden", 32'(imem_rden), 1);
    chk("first_addr", 32'(imem_addr), 0);
    @(negedge clk); chk("lat_n0", 32'(out_valid), 0);
    step(1, 0, '0);
    @(negedge clk); chk("lat_n1", 32'(out_valid), 0);
    step(1, 0, '0);
    @(negedge clk); chk("lat_n2", 32'(out_valid), 1);

    step(1, 0, '0);
    p0 = pops;
    repeat (20) step(1, 0, '0);
    chk("throughput", 32'(pops - p0), 20);

    // Back-pressure: queue saturates and fetch stops
    repeat (10) step(0, 0, '0);
    @(negedge clk);
    chk("sat_count", 32'(fifo_count), DEPTH);
    chk("sat_rden", 32'(imem_rden), 0);
    repeat (12) step(1, 0, '0);

    // Redirect with words queued and in flight
    repeat (3) step(0, 0, '0);
    step(0, 1, 10'h020);
    step(1, 0, '0);
    @(negedge clk); chk("redir_r1", 32'(out_valid), 0);
    step(1, 0, '0);
    @(negedge clk); chk("redir_r2", 32'(out_valid), 0);
    step(1, 0, '0);
    @(negedge clk);
    chk("redir_r3", 32'(out_valid), 1);
    chk("redir_pc", 32'(out_pc), 32'h20);
    repeat (5) step(1, 0, '0);

    // Consecutive redirects: only the latest target is delivered
    step(1, 1, 10'h010);
    step(1, 1, 10'h040);
    p0 = pops;
    repeat (8) step(1, 0, '0);
    chk("b2b_pops", 32'(pops - p0 > 0), 1);

    // Address wrap
    step(1, 1, 10'h3FE);
    p0 = pops;
    repeat (8) step(1, 0, '0);
    chk("wrap_pops", 32'(pops - p0 >= 4), 1);

    // Asynchronous reset with three queued entries
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(0, 0, '0);
      @(negedge clk);
      if (fifo_count == 3) got = 1;
    end
    chk("fill3", 32'(got), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_rden", 32'(imem_rden), 0);
    chk("arst_count", 32'(fifo_count), 0);
    chk("arst_instr", out_instr, NOP);
    restart('0);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rel_rden", 32'(imem_rden), 1);
    chk("rel_addr", 32'(imem_addr), 0);

    // Randomized traffic
    repeat (1500) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0), AW'($urandom));
    repeat (10) step(1, 0, '0);
    chk("min_pops", 32'(pops > 600), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
